// File: rtl/up_pkg.sv
// rtl/up_pkg.sv - shared widths, fetch-sequencer state type and instruction field slices
package up_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int INS_W_DEF  = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } fseq_state_t;

    // instruction word layout: {opcode[3:0], reg[1:0]}
    localparam int OPC_HI = 5;
    localparam int OPC_LO = 2;
    localparam int REG_HI = 1;
    localparam int REG_LO = 0;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - program-memory fetch and instruction-issue bus
interface fetch_sequencer_if import up_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INS_W  = INS_W_DEF
) ();

    logic [ADDR_W-1:0] pc_out;
    logic [INS_W-1:0]  ins_in;
    logic [INS_W-1:0]  ir_out;
    logic              ir_valid;
    logic              ex_ready;

    modport master (
        output pc_out, ir_out, ir_valid,
        input  ins_in, ex_ready
    );

    modport slave (
        input  pc_out, ir_out, ir_valid,
        output ins_in, ex_ready
    );

endinterface

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - program counter with load, wrapping increment and async reset
module pc_counter import up_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    // increment wraps naturally at 2**ADDR_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch/issue sequencer; BREAKPOINT_EN adds a sticky hardware breakpoint
module fetch_sequencer import up_pkg::*; #(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INS_W    = INS_W_DEF,
    parameter logic [ADDR_W-1:0] PROG_END = 5'd16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    fetch_sequencer_if.master bus,
    output logic              halted,
    output logic [7:0]        ret_cnt
`ifdef BREAKPOINT_EN
    ,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_enable,
    output logic              bp_hit
`endif
);

    fseq_state_t       state, state_nx;
    logic              free_run, free_run_nx;
    logic              pc_ld, pc_inc, retire;
    logic              bp_set, bp_clr, bp_match, bp_hit_q;
    logic [ADDR_W-1:0] pc;
    logic [INS_W-1:0]  ir;

    pc_counter #(.ADDR_W(ADDR_W)) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_ld),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc)
    );

`ifdef BREAKPOINT_EN
    assign bp_match = bp_enable && (pc == bp_addr);
    assign bp_hit   = bp_hit_q;
`else
    assign bp_match = 1'b0;
`endif

    assign bus.pc_out   = pc;
    assign bus.ir_out   = ir;
    assign bus.ir_valid = (state == ISSUE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        free_run_nx = free_run;
        pc_ld       = 1'b0;
        pc_inc      = 1'b0;
        retire      = 1'b0;
        bp_set      = 1'b0;
        bp_clr      = 1'b0;
        case (state)
            IDLE: begin
                if (pc_load) begin
                    pc_ld  = 1'b1;
                    bp_clr = 1'b1;
                end else if (step) begin
                    state_nx    = FETCH;
                    free_run_nx = 1'b0;
                    bp_clr      = 1'b1;
                end else if (run && !bp_hit_q) begin
                    state_nx    = FETCH;
                    free_run_nx = 1'b1;
                end
            end
            FETCH: state_nx = ISSUE;
            ISSUE: begin
                if (bus.ex_ready) begin
                    retire = 1'b1;
                    // the last program word halts and never arms the breakpoint
                    if (pc == PROG_END) begin
                        state_nx = HALT;
                    end else begin
                        pc_inc = 1'b1;
                        if (bp_match) begin
                            bp_set   = 1'b1;
                            state_nx = IDLE;
                        end else if (free_run && run) begin
                            state_nx = FETCH;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
            end
            HALT: begin
                if (pc_load) begin
                    pc_ld    = 1'b1;
                    bp_clr   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_run <= 1'b0;
            ir       <= '0;
            ret_cnt  <= '0;
            halted   <= 1'b0;
            bp_hit_q <= 1'b0;
        end else begin
            free_run <= free_run_nx;
            halted   <= (state_nx == HALT);
            if (state == FETCH) begin
                ir <= {bus.ins_in[OPC_HI:OPC_LO], bus.ins_in[REG_HI:REG_LO]};
            end
            if (retire) begin
                ret_cnt <= ret_cnt + 8'd1;
            end
            if (bp_set) begin
                bp_hit_q <= 1'b1;
            end else if (bp_clr) begin
                bp_hit_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the 8-bit accumulator core. It owns the program counter and drives the address of the 32 x 6-bit program memory, latches the returned instruction into an instruction register, and issues it to the datapath with a valid/ready handshake. It also provides run, single-step, PC-load and halt control, plus an optional hardware breakpoint for bring-up.

## Interface
Parameters:
- ADDR_W, 5, program-memory address width (32 words)
- INS_W, 6, instruction width ({opcode[3:0], reg[1:0]})
- PROG_END, 5'd16, address of the last program instruction; retiring it halts

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  level; free-run while high
- step  in  1  one-cycle pulse; execute exactly one instruction
- pc_load  in  1  load PC from pc_load_val
- pc_load_val  in  ADDR_W  new PC value
- ins_in  in  INS_W  program-memory data (combinational from pc_out)
- ex_ready  in  1  datapath accepts the issued instruction
- pc_out  out  ADDR_W  program-memory address (the PC register)
- ir_out  out  INS_W  latched instruction
- ir_valid  out  1  ir_out valid for the datapath
- halted  out  1  sequencer in HALT
- ret_cnt  out  8  retired-instruction counter, wraps 255->0
- bp_addr  in  ADDR_W  breakpoint address (BREAKPOINT_EN only)
- bp_enable  in  1  breakpoint armed (BREAKPOINT_EN only)
- bp_hit  out  1  sticky breakpoint flag (BREAKPOINT_EN only)

## Operation
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: PC held, ir_valid=0. Priority: pc_load (PC<=pc_load_val, stay IDLE) > step (->FETCH, single-shot) > run (->FETCH, free-run).
- FETCH: pc_out is stable. At the clock edge, ir<=ins_in. Next state is ISSUE.
- ISSUE: ir_valid=1. While ex_ready=0, hold ir_out, PC and ir_valid.
- Retirement in ISSUE happens on ex_ready=1:
  - ret_cnt increments.
  - If PC==PROG_END, go to HALT with PC unchanged.
  - Otherwise PC<=PC+1, wrapping 31->0.
  - Then go to FETCH if free-running and run=1 (and no breakpoint hit), else IDLE.
- Single-step always returns to IDLE after one retirement, even if run=1.
- HALT: halted=1. Only pc_load leaves it (PC<=pc_load_val, ->IDLE). run and step are ignored.
- pc_load in FETCH or ISSUE is ignored; an in-flight instruction always completes.
- run falling during FETCH/ISSUE: the current instruction completes, then the sequencer goes to IDLE.
- rst mid-operation: immediate return to reset values. An un-accepted instruction is dropped and not counted.

## Timing
- Reset values: pc_out=0, ir_out=0, ir_valid=0, halted=0, ret_cnt=0, bp_hit=0, state IDLE.
- Issue latency:
  - run/step sampled high in IDLE at edge N, FETCH during N..N+1.
  - ir_valid rises after edge N+1.
- Throughput is one instruction per 2 cycles when ex_ready is tied high.
- All outputs are registered except ir_valid, which is decoded from the state register.
- halted asserts the cycle after the PROG_END retirement edge.

## Configuration
- Macro BREAKPOINT_EN.
- Defined:
  - bp_addr, bp_enable and bp_hit exist.
  - On retiring the instruction at PC==bp_addr with bp_enable=1 (and PC!=PROG_END): PC advances normally, state goes to IDLE, and bp_hit sets.
  - While bp_hit=1, run is ignored in IDLE. step or pc_load clears bp_hit and acts normally.
  - A PROG_END retirement always halts and does not set bp_hit.
- Undefined: the ports are absent and behaviour is identical to bp_enable=0.

## Structure
- Shared package up_pkg holds:
  - ADDR_W/INS_W defaults
  - enum fseq_state_t {IDLE, FETCH, ISSUE, HALT}
  - opcode field slice constants
- One sub-module, pc_counter: PC register with load, increment, wrap and async reset. The FSM, IR and ret_cnt stay in fetch_sequencer.

## Test plan
- Reset, then run=1 with ex_ready=1 and a program of 17 words: pc_out steps 0..16. ir_out matches each word in turn. halted=1 after 17 retirements, with ret_cnt=17 and pc_out=16.
- Backpressure: ex_ready=0 for 3 cycles on word 2 -> ir_valid and ir_out held for 4 cycles, pc_out=2 throughout, ret_cnt increments once.
- Step: run=0, one step pulse -> exactly one ir_valid/ex_ready transfer, pc_out 0->1, state returns to IDLE. A second step -> pc_out=2.
- pc_load: in HALT, pc_load=1 with pc_load_val=5 -> halted=0, pc_out=5. The next step issues word 5. pc_load asserted during ISSUE is ignored.
- Wrap: PROG_END=31, start at PC=30 -> retire 30 and 31, then halt. Repeat with PROG_END=0 from PC=31 -> PC wraps 31->0 and halts at 0.
- BREAKPOINT_EN: bp_addr=3, bp_enable=1, run=1 -> after retiring 3, bp_hit=1 and pc_out=4, stays IDLE with run still high. A step clears bp_hit and issues word 4.
